apb_data_mem: RTL
=================

Name: apb_data_mem

Overview:
- APB3 completer (responder) backing the CPU's LW/SW data accesses. It is the other end of the bus driven by the CPU control unit's `apb_bus_ctrl` initiator.
- Contains a 16-bit-wide, word-addressed synchronous RAM, a programmable wait-state counter and out-of-range error signalling.
- Sits between the CPU APB initiator and the data address space.

Parameters:
- DEPTH, 256, number of 16-bit words; valid word addresses are 0..DEPTH-1.
- ADDR_W, 16, width of paddr.
- WAIT_STATES, 1, access-phase cycles with pready low before completion (0..15).

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset.
- psel  input  1  completer select.
- penable  input  1  access phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  word address.
- pwdata  input  16  write data.
- prdata  output  16  read data; valid only while pready=1 on a read.
- pready  output  1  transfer completes in this cycle.
- pslverr  output  1  transfer error; valid only while pready=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pready=0, pslverr=0, prdata=16'h0000; wait counter=0; latched addr/data/dir=0.
  - RAM contents are not cleared.
- All outputs are registered. There is no combinational path from any input to any output.
- States:
  - IDLE: pready=0.
    - On psel=1 & penable=0 (setup phase, cycle T0), latch paddr, pwrite, pwdata and in_range=(paddr<DEPTH).
    - Load cnt=WAIT_STATES and go to ACCESS.
    - If WAIT_STATES==0, set pready=1 at the same edge.
  - ACCESS (first cycle T1):
    - cnt>0 & psel & penable: cnt<=cnt-1, pready stays 0. pready is set to 1 at the edge where cnt goes 1->0.
    - pready=1 cycle: pready is high in cycle T1+WAIT_STATES. On the edge ending it, go to IDLE and clear pready/pslverr/prdata.
    - Abort: psel=0 or penable=0 while in ACCESS before completion (protocol violation) returns to IDLE at the next edge. No RAM write, pslverr=0, no pready pulse.
- Read: prdata is loaded from mem[latched addr] at the edge that raises pready. prdata=0 in every other cycle. Reads have no side effects.
- Write: mem[latched addr] <= latched pwdata at the edge ending the pready=1 cycle. This happens exactly once per transfer.
  - pwdata changes after T0 are ignored.
  - prdata=0 during writes.
- Out of range (paddr>=DEPTH): timing is unchanged.
  - pslverr=1 together with pready.
  - Read returns 16'h0000; write is suppressed.
- Back-to-back transfers: a new setup may occur in the cycle immediately after the pready=1 cycle (IDLE samples it). The minimum transfer is 2 cycles at WAIT_STATES=0.
- paddr/pwrite changes during ACCESS are ignored; only T0 values are used.
- psel=1 & penable=1 while in IDLE (no setup seen) is ignored. The block stays in IDLE with pready=0.
- Read-after-write to the same address in the next transfer returns the new data.
- Counter width is 4 bits. WAIT_STATES>15 is illegal (elaboration assertion).

Test Plan:
- Reset values: hold reset=0 for 3 cycles with random bus inputs. Required: pready=0, pslverr=0, prdata=0 throughout. After reset=1, stay idle.
- Write then read, WAIT_STATES=1:
  - Write 16'h1234 to addr 5: pready high exactly at T2.
  - Read addr 5: prdata=16'h1234, pslverr=0, at T2 of the read.
- Back-to-back, WAIT_STATES=0:
  - Write 16'hBEEF to addr 0, then write 16'h0001 to addr 255, with no idle cycles between transfers: each completes in 2 cycles.
  - Read addr 0, then read addr 255: returns 16'hBEEF, then 16'h0001.
- Out of range:
  - Write 16'hFFFF to addr 300: pready=1 and pslverr=1 in the completion cycle.
  - Read addr 300: prdata=0, pslverr=1.
  - Read addr 44 (300 mod 256): unchanged from its prior value.
- Abort, WAIT_STATES=3: start a write of 16'hAAAA to addr 7, then drop penable at T2. Required: no pready pulse, state returns to IDLE, and a read of addr 7 returns the old value.
- Reset mid-access, WAIT_STATES=2: assert reset during T1 of a write to addr 9. Required: outputs clear immediately (asynchronous), mem[9] is not modified, and a read issued after release completes normally.

Source files
------------

// File: rtl/apb_data_mem.sv
// APB3 completer: 16-bit word-addressed RAM with programmable wait states.
// Ports: clk, reset (async low), psel/penable/pwrite/paddr/pwdata in; prdata/pready/pslverr out.
module apb_data_mem #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [15:0]       pwdata,
  output logic [15:0]       prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("apb_data_mem: WAIT_STATES must be 0..15");
  end

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic [15:0]     wdata_q;
  logic            dir_q;
  logic            in_range_q;
  logic [15:0]     mem [DEPTH];

  logic            setup;
  logic            in_rng;
  logic [AW-1:0]   idx;
  logic            we;

  assign setup  = psel & ~penable;
  assign in_rng = {1'b0, paddr} < LIMIT;
  assign idx    = paddr[AW-1:0];

  // The write lands on the edge that closes the pready cycle.
  assign we = (state == ACCESS) & pready & dir_q & in_range_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dir_q      <= 1'b0;
      in_range_q <= 1'b0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      prdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            state      <= ACCESS;
            cnt        <= WS;
            addr_q     <= idx;
            wdata_q    <= pwdata;
            dir_q      <= pwrite;
            in_range_q <= in_rng;
            // Zero wait states: complete in the very first access cycle.
            if (WS == 4'd0) begin
              pready  <= 1'b1;
              pslverr <= ~in_rng;
              prdata  <= (!pwrite && in_rng) ? mem[idx] : '0;
            end
          end
        end
        ACCESS: begin
          if (pready) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
          end else if (!psel || !penable) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              pready  <= 1'b1;
              pslverr <= ~in_range_q;
              prdata  <= (!dir_q && in_range_q) ? mem[addr_q] : '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
